// File: rtl/control_pending_pkg.sv
`default_nettype none
// ============================================================================
// Module : control_pending_pkg
// Brief  : Register map and reset constants for the pending-capture block.
// Rev    : 1.0  initial release
// ============================================================================
package control_pending_pkg;

    localparam logic [1:0] ADDR_PENDING  = 2'd0;
    localparam logic [1:0] ADDR_IRQ_EN   = 2'd1;
    localparam logic [1:0] ADDR_EDGE     = 2'd2;
    localparam logic [1:0] ADDR_OVERFLOW = 2'd3;

    localparam int EDGE_RISE_OFS = 0;
    localparam int EDGE_FALL_OFS = 16;

    localparam logic [15:0] RISE_EN_RST = 16'hFFFF;
    localparam logic [15:0] FALL_EN_RST = 16'h0000;
    localparam logic [15:0] IRQ_EN_RST  = 16'h0000;

endpackage : control_pending_pkg
`default_nettype wire

// File: rtl/control_pending_sync.sv
`default_nettype none
// ============================================================================
// Module : control_pending_sync
// Brief  : Single-bit flop-chain synchroniser, asynchronous reset to 0.
// Rev    : 1.0  initial release
// ============================================================================
module control_pending_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic async_in,
    output logic sync_out
);

    logic [SYNC_STAGES-1:0] r_chain;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[SYNC_STAGES-2:0], async_in};
        end
    end

    assign sync_out = r_chain[SYNC_STAGES-1];

endmodule : control_pending_sync
`default_nettype wire

// File: rtl/control_pending_capture.sv
`default_nettype none
// ============================================================================
// Module : control_pending_capture
// Brief  : Synchronised edge capture into sticky pending flags with an
//          Avalon-MM slave for W1C, edge select, irq enable and overflow.
// Rev    : 1.0  initial release
// ============================================================================
module control_pending_capture
    import control_pending_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] event_in,
    input  logic [1:0]       address,
    input  logic             write,
    input  logic [31:0]      writedata,
    input  logic             read,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] pending_out,
    output logic             irq
);

    logic [WIDTH-1:0] w_sync;
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_pending;
    logic [WIDTH-1:0] r_overflow;
    logic [WIDTH-1:0] r_irq_en;
    logic [WIDTH-1:0] r_rise_en;
    logic [WIDTH-1:0] r_fall_en;
    logic [31:0]      r_readdata;
    logic             r_irq;

    logic [WIDTH-1:0] w_det;
    logic [WIDTH-1:0] w_pend_w1c;
    logic [WIDTH-1:0] w_ovf_w1c;
    logic [WIDTH-1:0] w_pending_next;
    logic [WIDTH-1:0] w_overflow_next;
    logic [WIDTH-1:0] w_irq_en_next;
    logic             w_wr_irq_en;
    logic             w_wr_edge;
    logic [31:0]      w_rdata;
    logic             w_unused;

    for (genvar i = 0; i < WIDTH; i++) begin : g_sync
        control_pending_sync #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_sync (
            .clk      (clk),
            .reset_n  (reset_n),
            .async_in (event_in[i]),
            .sync_out (w_sync[i])
        );
    end

    assign w_det = (w_sync & ~r_prev & r_rise_en) | (~w_sync & r_prev & r_fall_en);

    assign w_pend_w1c  = (write && address == ADDR_PENDING)  ? writedata[WIDTH-1:0] : '0;
    assign w_ovf_w1c   = (write && address == ADDR_OVERFLOW) ? writedata[WIDTH-1:0] : '0;
    assign w_wr_irq_en = write && (address == ADDR_IRQ_EN);
    assign w_wr_edge   = write && (address == ADDR_EDGE);

    // Set wins over W1C; an overflow only counts if the flag is not being cleared.
    assign w_pending_next  = w_det | (r_pending & ~w_pend_w1c);
    assign w_overflow_next = (w_det & r_pending & ~w_pend_w1c) | (r_overflow & ~w_ovf_w1c);
    assign w_irq_en_next   = w_wr_irq_en ? writedata[WIDTH-1:0] : r_irq_en;

    always_comb begin
        w_rdata = '0;
        case (address)
            ADDR_PENDING:  w_rdata[WIDTH-1:0] = r_pending;
            ADDR_IRQ_EN:   w_rdata[WIDTH-1:0] = r_irq_en;
            ADDR_EDGE: begin
                w_rdata[EDGE_RISE_OFS +: WIDTH] = r_rise_en;
                w_rdata[EDGE_FALL_OFS +: WIDTH] = r_fall_en;
            end
            default:       w_rdata[WIDTH-1:0] = r_overflow;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prev     <= '0;
            r_pending  <= '0;
            r_overflow <= '0;
            r_irq_en   <= IRQ_EN_RST[WIDTH-1:0];
            r_rise_en  <= RISE_EN_RST[WIDTH-1:0];
            r_fall_en  <= FALL_EN_RST[WIDTH-1:0];
            r_readdata <= '0;
            r_irq      <= 1'b0;
        end else begin
            r_prev     <= w_sync;
            r_pending  <= w_pending_next;
            r_overflow <= w_overflow_next;
            r_irq_en   <= w_irq_en_next;
            if (w_wr_edge) begin
                r_rise_en <= writedata[EDGE_RISE_OFS +: WIDTH];
                r_fall_en <= writedata[EDGE_FALL_OFS +: WIDTH];
            end
            if (read) begin
                r_readdata <= w_rdata;
            end
            r_irq <= |(w_pending_next & w_irq_en_next);
        end
    end

    assign pending_out = r_pending;
    assign readdata    = r_readdata;
    assign irq         = r_irq;

    // Upper writedata bits are reserved and deliberately ignored.
    assign w_unused = &{1'b0, writedata};

endmodule : control_pending_capture
`default_nettype wire

// File: tb/tb_control_pending_capture.sv
`default_nettype none
// ============================================================================
// Module : tb_control_pending_capture
// Brief  : Directed self-checking bench with an expected-value scoreboard.
// Rev    : 1.0  initial release
// ============================================================================
module tb_control_pending_capture;

    logic        clk       = 1'b0;
    logic        reset_n   = 1'b0;
    logic [7:0]  event_in  = '0;
    logic [1:0]  address   = '0;
    logic        write     = 1'b0;
    logic [31:0] writedata = '0;
    logic        read      = 1'b0;
    logic [31:0] readdata;
    logic [7:0]  pending_out;
    logic        irq;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_t;

    sb_t sb_q[$];
    int  total = 0;
    int  bad   = 0;

    control_pending_capture #(
        .WIDTH       (8),
        .SYNC_STAGES (2)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .event_in    (event_in),
        .address     (address),
        .write       (write),
        .writedata   (writedata),
        .read        (read),
        .readdata    (readdata),
        .pending_out (pending_out),
        .irq         (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic sb_push(input string tag, input logic [31:0] exp);
        sb_t e;
        e.tag = tag;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic sb_check(input logic [31:0] obs);
        sb_t e;
        total++;
        if (sb_q.size() == 0) begin
            bad++;
            $error("FAIL sb_empty: observed=0x%0h expected=none", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.exp) else begin
                bad++;
                $error("FAIL %s: observed=0x%0h expected=0x%0h", e.tag, obs, e.exp);
            end
        end
    endtask

    // Leaves the bench 1 time unit after a rising edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic av_write(input logic [1:0] a, input logic [31:0] d);
        address   = a;
        writedata = d;
        write     = 1'b1;
        tick(1);
        write     = 1'b0;
    endtask

    task automatic av_read(input logic [1:0] a, input string tag, input logic [31:0] exp);
        sb_push(tag, exp);
        address = a;
        read    = 1'b1;
        tick(1);
        read    = 1'b0;
        sb_check(readdata);
    endtask

    task automatic chk_pend(input string tag, input logic [7:0] exp);
        sb_push(tag, {24'h0, exp});
        sb_check({24'h0, pending_out});
    endtask

    task automatic chk_irq(input string tag, input logic exp);
        sb_push(tag, {31'h0, exp});
        sb_check({31'h0, irq});
    endtask

    initial begin
        // Reset defaults
        tick(2);
        chk_pend("rst_hold_pend", 8'h00);
        chk_irq("rst_hold_irq", 1'b0);
        sb_push("rst_hold_rdata", 32'h0);
        sb_check(readdata);
        #3 reset_n = 1'b1;
        tick(1);
        av_read(2'd0, "rst_pending", 32'h0);
        av_read(2'd1, "rst_irq_en", 32'h0);
        av_read(2'd2, "rst_edge", 32'h0000_00FF);
        av_read(2'd3, "rst_overflow", 32'h0);
        chk_irq("rst_irq", 1'b0);
        chk_pend("rst_pend_out", 8'h00);

        // Rising edge capture on channel 3
        event_in[3] = 1'b1;
        tick(2);
        chk_pend("rise_n2", 8'h00);
        tick(1);
        chk_pend("rise_n3", 8'h08);
        av_read(2'd0, "rise_read", 32'h08);
        av_write(2'd0, 32'h08);
        chk_pend("rise_w1c", 8'h00);
        event_in[3] = 1'b0;
        tick(4);
        chk_pend("rise_fall_ignored", 8'h00);

        // Falling edge only on channel 0
        av_write(2'd2, 32'h0001_0000);
        av_read(2'd2, "fall_edge_rb", 32'h0001_0000);
        event_in[0] = 1'b1;
        tick(4);
        chk_pend("fall_rise_ignored", 8'h00);
        event_in[0] = 1'b0;
        tick(2);
        chk_pend("fall_n2", 8'h00);
        tick(1);
        chk_pend("fall_n3", 8'h01);
        av_write(2'd0, 32'h01);
        chk_pend("fall_w1c", 8'h00);
        av_write(2'd2, 32'h0000_00FF);

        // Overflow on channel 5
        event_in[5] = 1'b1;
        tick(3);
        chk_pend("ovf_first", 8'h20);
        event_in[5] = 1'b0;
        tick(4);
        event_in[5] = 1'b1;
        tick(3);
        chk_pend("ovf_second", 8'h20);
        av_read(2'd3, "ovf_read", 32'h20);
        av_write(2'd3, 32'h20);
        av_read(2'd3, "ovf_cleared", 32'h0);
        event_in[5] = 1'b0;
        tick(4);
        // Detection lands on the same edge as the W1C: set wins, no overflow.
        event_in[5] = 1'b1;
        tick(2);
        av_write(2'd0, 32'h20);
        chk_pend("setwins_pend", 8'h20);
        av_read(2'd3, "setwins_ovf", 32'h0);
        event_in[5] = 1'b0;
        av_write(2'd0, 32'h20);
        chk_pend("setwins_clr", 8'h00);

        // IRQ gating
        event_in[1:0] = 2'b11;
        tick(3);
        chk_pend("irq_pend", 8'h03);
        chk_irq("irq_disabled", 1'b0);
        av_write(2'd1, 32'h02);
        chk_irq("irq_enabled", 1'b1);
        av_write(2'd0, 32'h02);
        chk_irq("irq_w1c", 1'b0);
        chk_pend("irq_pend_left", 8'h01);
        event_in = '0;
        av_write(2'd0, 32'h01);

        // Asynchronous reset mid-burst
        av_write(2'd1, 32'hFF);
        av_read(2'd2, "burst_edge", 32'h0000_00FF);
        for (int i = 0; i < 6; i++) begin
            event_in = i[0] ? 8'hA5 : 8'h5A;
            tick(1);
        end
        #2 reset_n = 1'b0;
        #1;
        chk_pend("async_pend", 8'h00);
        chk_irq("async_irq", 1'b0);
        sb_push("async_rdata", 32'h0);
        sb_check(readdata);
        event_in = '0;
        tick(1);
        #3 reset_n = 1'b1;
        tick(1);
        av_read(2'd1, "post_irq_en", 32'h0);
        av_read(2'd2, "post_edge", 32'h0000_00FF);
        chk_pend("post_pend", 8'h00);

        total++;
        assert (sb_q.size() == 0) else begin
            bad++;
            $error("FAIL sb_leftover: observed=%0d expected=0", sb_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_control_pending_capture
`default_nettype wire
